// File: rtl/ahb_manager_elastic_buffer.sv
// rtl/ahb_manager_elastic_buffer.sv - N-entry elastic buffer with registered upstream stall
module ahb_manager_elastic_buffer #(
    parameter int WDT     = 32,
    parameter int DEPTH   = 2,
    parameter bit REG_OUT = 1'b0
) (
    input  logic                       i_hclk,
    input  logic                       i_hreset_n,
    input  logic                       i_flush,
    input  logic                       i_valid,
    input  logic [WDT-1:0]             i_data,
    output logic                       o_stall,
    output logic                       o_valid,
    output logic [WDT-1:0]             o_data,
    input  logic                       i_stall,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WDT-1:0] mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [LW-1:0]  count;
    logic [LW-1:0]  count_nxt;
    logic           stall_q;
    logic           empty;
    logic           accept;
    logic           transfer;
    logic           bypass;
    logic           push;
    logic           pop;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign o_stall = stall_q;
    assign o_level = count;

    always_comb begin
        o_valid = !empty;
        o_data  = mem[rd_ptr];
        if (!REG_OUT) begin
            o_valid = !empty || i_valid;
            o_data  = empty ? i_data : mem[rd_ptr];
        end
    end

    assign accept    = i_valid && !stall_q;
    assign transfer  = o_valid && !i_stall;
    // An empty buffer hands a beat straight through when the consumer takes it.
    assign bypass    = !REG_OUT && empty && i_valid && !i_stall;
    assign push      = accept && !bypass;
    assign pop       = transfer && !empty;
    assign count_nxt = count + LW'(push) - LW'(pop);

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            stall_q <= 1'b0;
        end else if (i_flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            stall_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count   <= count_nxt;
            stall_q <= (count_nxt == FULL);
        end
    end

    always_ff @(posedge i_hclk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    always @(posedge i_hclk) begin
        if (i_hreset_n) begin
            assert (!(push && count == FULL));
            assert (!(pop && empty));
        end
    end

endmodule

// File: tb/tb_ahb_manager_elastic_buffer.sv
// tb/tb_ahb_manager_elastic_buffer.sv - self-checking bench for ahb_manager_elastic_buffer
module tb_ahb_manager_elastic_buffer;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       v  [4];
    logic       st [4];
    logic       fl [4];
    logic [7:0] d  [4];
    logic       os [4];
    logic       ov [4];
    logic [7:0] od [4];
    logic [1:0] lv0;
    logic [1:0] lv1;
    logic [2:0] lv2;
    logic [1:0] lv3;

    int total  = 0;
    int passed = 0;

    logic [7:0] sb [$];
    logic       acc;
    logic       xf;
    logic       pend;
    logic [7:0] nxt;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       st;
        logic       ov;
        logic [7:0] od;
        logic       os;
        logic [1:0] lvl;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    ahb_manager_elastic_buffer #(.WDT(8), .DEPTH(2), .REG_OUT(1'b0)) u_a (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_flush(fl[0]), .i_valid(v[0]), .i_data(d[0]),
        .o_stall(os[0]), .o_valid(ov[0]), .o_data(od[0]), .i_stall(st[0]), .o_level(lv0));

    ahb_manager_elastic_buffer #(.WDT(8), .DEPTH(3), .REG_OUT(1'b0)) u_b (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_flush(fl[1]), .i_valid(v[1]), .i_data(d[1]),
        .o_stall(os[1]), .o_valid(ov[1]), .o_data(od[1]), .i_stall(st[1]), .o_level(lv1));

    ahb_manager_elastic_buffer #(.WDT(8), .DEPTH(4), .REG_OUT(1'b0)) u_c (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_flush(fl[2]), .i_valid(v[2]), .i_data(d[2]),
        .o_stall(os[2]), .o_valid(ov[2]), .o_data(od[2]), .i_stall(st[2]), .o_level(lv2));

    ahb_manager_elastic_buffer #(.WDT(8), .DEPTH(2), .REG_OUT(1'b1)) u_d (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_flush(fl[3]), .i_valid(v[3]), .i_data(d[3]),
        .o_stall(os[3]), .o_valid(ov[3]), .o_data(od[3]), .i_stall(st[3]), .o_level(lv3));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    endtask

    task automatic drv(input int i, input logic vv, input logic [7:0] dd, input logic ss, input logic ff);
        v[i]  = vv;
        d[i]  = dd;
        st[i] = ss;
        fl[i] = ff;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0, 2'd0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 1'b0, 2'd0};
        tbl[3] = '{1'b1, 8'h0A, 1'b1, 1'b1, 8'h0A, 1'b0, 2'd0};
        tbl[4] = '{1'b1, 8'h0B, 1'b1, 1'b1, 8'h0A, 1'b0, 2'd1};
        tbl[5] = '{1'b1, 8'h0C, 1'b1, 1'b1, 8'h0A, 1'b1, 2'd2};
        tbl[6] = '{1'b1, 8'h0C, 1'b0, 1'b1, 8'h0A, 1'b1, 2'd2};
        tbl[7] = '{1'b1, 8'h0C, 1'b0, 1'b1, 8'h0B, 1'b0, 2'd1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h0C, 1'b0, 2'd1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0};

        // Reset state with every upstream valid asserted.
        for (int i = 0; i < 4; i++) drv(i, 1'b1, 8'h3C, 1'b0, 1'b0);
        #12;
        chk("rst_a_valid_follows", ov[0], 1);
        chk("rst_a_data_bypass", od[0], 8'h3C);
        chk("rst_d_valid", ov[3], 0);
        chk("rst_levels", {lv0, lv1, lv2, lv3}, 0);
        chk("rst_stalls", {os[0], os[1], os[2], os[3]}, 0);
        for (int i = 0; i < 4; i++) drv(i, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // Bypass streaming, fill to full, hold, then drain in order.
        for (int i = 0; i < 10; i++) begin
            drv(0, tbl[i].v, tbl[i].d, tbl[i].st, 1'b0);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), ov[0], tbl[i].ov);
            if (tbl[i].ov) chk($sformatf("tbl%0d_data", i), od[0], tbl[i].od);
            chk($sformatf("tbl%0d_stall", i), os[0], tbl[i].os);
            chk($sformatf("tbl%0d_level", i), lv0, tbl[i].lvl);
            tick();
        end

        // REG_OUT=1: one cycle of latency from an empty buffer.
        drv(3, 1'b1, 8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        chk("reg_out_no_bypass", ov[3], 0);
        tick();
        drv(3, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("reg_out_valid", ov[3], 1);
        chk("reg_out_data", od[3], 8'h5A);
        chk("reg_out_level", lv3, 1);
        tick();
        @(negedge clk);
        chk("reg_out_drained", ov[3], 0);
        chk("reg_out_level0", lv3, 0);
        tick();

        // DEPTH=4 fill then flush; flushed beats never reappear.
        for (int i = 0; i < 4; i++) begin
            drv(2, 1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
            tick();
        end
        drv(2, 1'b1, 8'h99, 1'b1, 1'b1);
        @(negedge clk);
        chk("c_full_level", lv2, 4);
        chk("c_full_stall", os[2], 1);
        chk("c_head", od[2], 8'hC0);
        tick();
        drv(2, 1'b1, 8'h77, 1'b1, 1'b0);
        @(negedge clk);
        chk("c_flush_level", lv2, 0);
        chk("c_flush_stall", os[2], 0);
        chk("c_flush_valid", ov[2], 1);
        chk("c_flush_data", od[2], 8'h77);
        tick();
        drv(2, 1'b1, 8'h55, 1'b1, 1'b1);
        @(negedge clk);
        chk("c_push_after_flush", lv2, 1);
        chk("c_push_data", od[2], 8'h77);
        tick();
        drv(2, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("c_flush2_valid", ov[2], 0);
        chk("c_flush2_level", lv2, 0);
        tick();
        drv(2, 1'b1, 8'h67, 1'b1, 1'b0);
        tick();
        drv(2, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("c_post_flush_data", od[2], 8'h67);
        chk("c_post_flush_valid", ov[2], 1);
        tick();

        // DEPTH=3 random traffic against a FIFO scoreboard.
        pend = 1'b0;
        nxt  = 8'h00;
        for (int i = 0; i < 10000; i++) begin
            if (!pend) begin
                v[1] = ($urandom_range(0, 99) < 60);
                d[1] = nxt;
                if (v[1]) nxt++;
            end
            st[1] = ($urandom_range(0, 99) < 45);
            @(negedge clk);
            chk("b_level", lv1, sb.size());
            chk("b_stall", os[1], int'(sb.size() == 3));
            chk("b_valid", ov[1], int'(sb.size() != 0 || v[1]));
            acc  = v[1] && !os[1];
            xf   = ov[1] && !st[1];
            pend = v[1] && !acc;
            if (acc) sb.push_back(d[1]);
            if (xf && sb.size() > 0) chk("b_data", od[1], sb.pop_front());
            tick();
        end
        drv(1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ov[1] && sb.size() > 0) chk("b_drain_data", od[1], sb.pop_front());
            tick();
        end
        chk("b_drained_level", lv1, 0);
        chk("b_drained_valid", ov[1], 0);

        // Asynchronous reset mid-burst.
        drv(0, 1'b1, 8'hE1, 1'b1, 1'b0);
        tick();
        drv(0, 1'b1, 8'hE2, 1'b1, 1'b0);
        tick();
        drv(0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("a_pre_reset_level", lv0, 2);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_async_level", lv0, 0);
        chk("a_async_stall", os[0], 0);
        tick();
        rst_n = 1'b1;
        drv(0, 1'b1, 8'hF1, 1'b1, 1'b0);
        @(negedge clk);
        chk("a_post_reset_view", od[0], 8'hF1);
        tick();
        drv(0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("a_post_reset_first", od[0], 8'hF1);
        chk("a_post_reset_level", lv0, 1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
